// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the byte FIFO write port among N_REQ valid/ready producers.
// A grant lasts up to MAX_BURST accepted beats and stalls, without timing out, while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int GNT_W      = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        full,
  output logic                        WREN,
  output logic [DATA_WIDTH-1:0]       data_in,
  output logic [GNT_W-1:0]            grant_id,
  output logic                        busy
);

  localparam int                CNT_W     = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [GNT_W-1:0]  LAST_REQ  = GNT_W'(N_REQ - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e                  state_q, state_d;
  logic [GNT_W-1:0]        grant_q, grant_d;
  logic [GNT_W-1:0]        last_q, last_d;
  logic [CNT_W-1:0]        beat_q, beat_d;

  logic [DATA_WIDTH-1:0]   slice [N_REQ];
  logic                    pick_found;
  logic [GNT_W-1:0]        pick_idx;
  logic [GNT_W-1:0]        scan_idx;
  logic                    cur_valid;
  logic                    accept;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan starts just after the last releaser, so it naturally has lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    scan_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = last_q + GNT_W'(k);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Ready is derived from state and full only, never from req_valid.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    cur_valid = req_valid[grant_q];
    busy      = (state_q == GRANT);
    if (state_q == GRANT) begin
      req_ready[grant_q] = !full;
      accept             = cur_valid && !full;
    end
    WREN    = accept;
    data_in = accept ? slice[grant_q] : '0;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          grant_d = pick_idx;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          beat_d = beat_q + CNT_W'(1);
        end
        if ((accept && (beat_q == LAST_BEAT)) || !cur_valid) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_REQ;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  assign grant_id = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed table-driven bench for fifo_wr_arbiter (MAX_BURST=4), plus hand-written
// sequences for mid-burst asynchronous reset and a MAX_BURST=1 instance.
module tb_fifo_wr_arbiter;

  localparam logic [31:0] DATA_STD = 32'h1312_1110;
  localparam logic [31:0] DATA_A   = 32'h1312_111B;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = DATA_STD;
  logic [3:0]  req_ready;
  logic        full = 1'b0;
  logic        WREN;
  logic [7:0]  data_in;
  logic [1:0]  grant_id;
  logic        busy;

  logic [3:0]  req_valid1 = '0;
  logic [31:0] req_data1 = 32'h0000_A1A0;
  logic [3:0]  req_ready1;
  logic        full1 = 1'b0;
  logic        WREN1;
  logic [7:0]  data_in1;
  logic [1:0]  grant_id1;
  logic        busy1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic        full;
    logic [31:0] data;
    logic [3:0]  expReady;
    logic        expWren;
    logic [7:0]  expData;
    logic [1:0]  expGnt;
    logic        expBusy;
  } vec_t;

  vec_t vecs[$];

  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .full(full), .WREN(WREN), .data_in(data_in),
    .grant_id(grant_id), .busy(busy)
  );

  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_data(req_data1),
    .req_ready(req_ready1), .full(full1), .WREN(WREN1), .data_in(data_in1),
    .grant_id(grant_id1), .busy(busy1)
  );

  always #5 clk = ~clk;

  function automatic void addRow(input logic rst, input logic [3:0] valid, input logic fl,
                                 input logic [31:0] data, input logic [3:0] rdy, input logic wr,
                                 input logic [7:0] dout, input logic [1:0] gnt, input logic bsy);
    vec_t v;
    v.rst = rst; v.valid = valid; v.full = fl; v.data = data;
    v.expReady = rdy; v.expWren = wr; v.expData = dout; v.expGnt = gnt; v.expBusy = bsy;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    check({tag, ".ready"}, 32'(req_ready), 32'(v.expReady));
    check({tag, ".wren"},  32'(WREN),      32'(v.expWren));
    check({tag, ".data"},  32'(data_in),   32'(v.expData));
    check({tag, ".gnt"},   32'(grant_id),  32'(v.expGnt));
    check({tag, ".busy"},  32'(busy),      32'(v.expBusy));
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    reset     = v.rst;
    req_valid = v.valid;
    full      = v.full;
    req_data  = v.data;
    #1;
    checkOutput(v, tag);
  endtask

  initial begin
    // Single requester: four beats, IDLE bubble, re-grant, then valid drop
    addRow(1, 4'b0000, 0, DATA_A, 4'b0000, 0, 8'h00, 0, 0);
    addRow(0, 4'b0001, 0, DATA_A, 4'b0000, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) addRow(0, 4'b0001, 0, DATA_A, 4'b0001, 1, 8'h1B, 0, 1);
    addRow(0, 4'b0001, 0, DATA_A, 4'b0000, 0, 8'h00, 0, 0);
    addRow(0, 4'b0001, 0, DATA_A, 4'b0001, 1, 8'h1B, 0, 1);
    addRow(0, 4'b0000, 0, DATA_A, 4'b0001, 0, 8'h00, 0, 1);
    addRow(0, 4'b0000, 0, DATA_A, 4'b0000, 0, 8'h00, 0, 0);

    // Round-robin 0,1,2,3 then wrap to 0
    addRow(1, 4'b1111, 0, DATA_STD, 4'b0000, 0, 8'h00, 0, 0);
    addRow(0, 4'b1111, 0, DATA_STD, 4'b0000, 0, 8'h00, 0, 0);
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++)
        addRow(0, 4'b1111, 0, DATA_STD, 4'(1 << g), 1, 8'(8'h10 + g), 2'(g), 1);
      addRow(0, 4'b1111, 0, DATA_STD, 4'b0000, 0, 8'h00, 2'(g), 0);
    end
    addRow(0, 4'b1111, 0, DATA_STD, 4'b0001, 1, 8'h10, 0, 1);
    addRow(0, 4'b0000, 0, DATA_STD, 4'b0001, 0, 8'h00, 0, 1);
    addRow(0, 4'b0000, 0, DATA_STD, 4'b0000, 0, 8'h00, 0, 0);

    // Full stall on requester 2 after two beats
    addRow(1, 4'b0000, 0, DATA_STD, 4'b0000, 0, 8'h00, 0, 0);
    addRow(0, 4'b0100, 0, DATA_STD, 4'b0000, 0, 8'h00, 0, 0);
    for (int i = 0; i < 2; i++) addRow(0, 4'b0100, 0, DATA_STD, 4'b0100, 1, 8'h12, 2, 1);
    for (int i = 0; i < 5; i++) addRow(0, 4'b0100, 1, DATA_STD, 4'b0000, 0, 8'h00, 2, 1);
    for (int i = 0; i < 2; i++) addRow(0, 4'b0100, 0, DATA_STD, 4'b0100, 1, 8'h12, 2, 1);
    addRow(0, 4'b0000, 0, DATA_STD, 4'b0000, 0, 8'h00, 2, 0);

    // Early release of requester 1, waiting requester 3 granted next; drop under full
    addRow(1, 4'b0000, 0, DATA_STD, 4'b0000, 0, 8'h00, 0, 0);
    addRow(0, 4'b1010, 0, DATA_STD, 4'b0000, 0, 8'h00, 0, 0);
    addRow(0, 4'b1010, 0, DATA_STD, 4'b0010, 1, 8'h11, 1, 1);
    addRow(0, 4'b1000, 0, DATA_STD, 4'b0010, 0, 8'h00, 1, 1);
    addRow(0, 4'b1000, 0, DATA_STD, 4'b0000, 0, 8'h00, 1, 0);
    addRow(0, 4'b1000, 0, DATA_STD, 4'b1000, 1, 8'h13, 3, 1);
    addRow(0, 4'b0000, 1, DATA_STD, 4'b0000, 0, 8'h00, 3, 1);
    addRow(0, 4'b0000, 0, DATA_STD, 4'b0000, 0, 8'h00, 3, 0);

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("row%0d", i));

    // Mid-burst asynchronous reset while requester 1 holds the grant
    vecs.delete();
    addRow(1, 4'b0000, 0, DATA_STD, 4'b0000, 0, 8'h00, 0, 0);
    addRow(0, 4'b0010, 0, DATA_STD, 4'b0000, 0, 8'h00, 0, 0);
    addRow(0, 4'b0010, 0, DATA_STD, 4'b0010, 1, 8'h11, 1, 1);
    addRow(0, 4'b0010, 0, DATA_STD, 4'b0010, 1, 8'h11, 1, 1);
    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("arst%0d", i));
    @(posedge clk);
    #3;
    reset     = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("arst.wren",  32'(WREN),      32'h0);
    check("arst.ready", 32'(req_ready), 32'h0);
    check("arst.busy",  32'(busy),      32'h0);
    check("arst.data",  32'(data_in),   32'h0);
    check("arst.gnt",   32'(grant_id),  32'h0);
    vecs.delete();
    addRow(1, 4'b1111, 0, DATA_STD, 4'b0000, 0, 8'h00, 0, 0);
    addRow(0, 4'b1111, 0, DATA_STD, 4'b0000, 0, 8'h00, 0, 0);
    addRow(0, 4'b1111, 0, DATA_STD, 4'b0001, 1, 8'h10, 0, 1);
    addRow(0, 4'b0000, 0, DATA_STD, 4'b0001, 0, 8'h00, 0, 1);
    addRow(0, 4'b0000, 0, DATA_STD, 4'b0000, 0, 8'h00, 0, 0);
    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("post%0d", i));

    // MAX_BURST=1 instance: single-beat grants alternate 0,1,0,1 with IDLE between
    for (int k = 0; k < 9; k++) begin
      logic       eBusy;
      logic [1:0] eGnt;
      @(negedge clk);
      req_valid1 = 4'b0011;
      #1;
      eBusy = (k % 2 == 1);
      eGnt  = (k == 0) ? 2'd0 : 2'(((k - 1) / 2) % 2);
      check($sformatf("mb1.%0d.busy", k),  32'(busy1),      32'(eBusy));
      check($sformatf("mb1.%0d.gnt", k),   32'(grant_id1),  32'(eGnt));
      check($sformatf("mb1.%0d.wren", k),  32'(WREN1),      32'(eBusy));
      check($sformatf("mb1.%0d.ready", k), 32'(req_ready1), eBusy ? 32'(1 << eGnt) : 32'h0);
      check($sformatf("mb1.%0d.data", k),  32'(data_in1),   eBusy ? 32'(8'hA0 + eGnt) : 32'h0);
    end
    req_valid1 = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
